dmem_ctrl: RTL and testbench

Parametrised data-memory controller that replaces the bare single-cycle data memory behind the pipeline's load/store path.
- Accepts one request per cycle over a valid/ready handshake.
- Supports byte-enabled writes.
- Returns every request's response after a configurable read latency.
- Buffers responses in a credit-limited FIFO so the core can stall the response channel without losing data.

---
 rtl/dmem_ctrl_pkg.sv | 18 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/dmem_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared defaults and helpers for the data-memory controller slice.
//   RV32_ADDR_WIDTH / DMEM_DATA_WIDTH  : core address/word widths
//   DMEM_DEPTH                         : default memory depth in words
//   DMEM_CTRL_RD_LATENCY / _RESP_DEPTH : default latency and response buffering
package dmem_ctrl_pkg;

  localparam int unsigned RV32_ADDR_WIDTH      = 32;
  localparam int unsigned DMEM_DATA_WIDTH      = 32;
  localparam int unsigned DMEM_DEPTH           = 1024;
  localparam int unsigned DMEM_CTRL_RD_LATENCY = 2;
  localparam int unsigned DMEM_CTRL_RESP_DEPTH = 4;

  // Index width that stays at least one bit for degenerate depths.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write request and entry
//   pop, pop_data   : read request and head entry (zero when empty)
//   count/full/empty: occupancy status, full/empty derived from count
module sync_fifo
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  pop_data,
  output logic [safe_clog2(DEPTH+1)-1:0]    count,
  output logic                              full,
  output logic                              empty
);

  localparam int unsigned PTR_W = safe_clog2(DEPTH);
  localparam int unsigned CNT_W = safe_clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_en;
  logic             push_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  // A push on a full FIFO only lands when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-enabled word memory behind a valid/ready
// request port, fixed read-latency pipeline and credit-limited response FIFO.
//   clk, rst                     : clock, asynchronous active-high reset
//   i_req_valid / o_req_ready    : request handshake
//   i_req_wr_en, i_req_addr,
//   i_req_wr_data, i_req_byte_en : request payload (byte address)
//   o_resp_valid / i_resp_ready  : response handshake (FIFO head)
//   o_resp_rd_data, o_resp_err   : response payload
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RV32_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned DEPTH      = DMEM_DEPTH,
  parameter int unsigned RD_LATENCY = DMEM_CTRL_RD_LATENCY,
  parameter int unsigned RESP_DEPTH = DMEM_CTRL_RESP_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_req_byte_en,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_resp_rd_data,
  output logic                    o_resp_err
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = safe_clog2(DEPTH);
  localparam int unsigned OUT_W = safe_clog2(RESP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  pop;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_err;
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
  logic [OUT_W-1:0]      pipe_cnt;

  logic [OUT_W-1:0]      outstanding;
  logic [DATA_WIDTH:0]   head;
  logic [OUT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign accept   = i_req_valid && o_req_ready;
  assign pop      = o_resp_valid && i_resp_ready;
  assign word_idx = i_req_addr >> OFF_W;
  assign mem_idx  = word_idx[IDX_W-1:0];
  // Misaligned or past the end; the extra bit keeps DEPTH itself representable.
  assign fault    = ((i_req_addr & ADDR_WIDTH'(BYTES - 1)) != '0)
                 || ({1'b0, word_idx} >= (ADDR_WIDTH+1)'(DEPTH));

  // Credits cover both the pipeline and the FIFO, so the FIFO cannot overflow.
  assign o_req_ready = (outstanding < OUT_W'(RESP_DEPTH));

  // Byte-lane stores; faulting stores never touch the array.
  always_ff @(posedge clk) begin
    if (accept && i_req_wr_en && !fault) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_req_byte_en[b]) mem[mem_idx][b*8 +: 8] <= i_req_wr_data[b*8 +: 8];
      end
    end
  end

  // Latency pipeline; stage 0 reads the array before this edge's store lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= accept;
      pipe_err[0]  <= accept && fault;
      pipe_data[0] <= (accept && !i_req_wr_en && !fault) ? mem[mem_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_err[i]  <= pipe_err[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Outstanding credit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_vld[RD_LATENCY-1]),
    .push_data ({pipe_err[RD_LATENCY-1], pipe_data[RD_LATENCY-1]}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_resp_valid   = !fifo_empty;
  assign o_resp_err     = head[DATA_WIDTH];
  assign o_resp_rd_data = head[DATA_WIDTH-1:0];

  // Valid stages in flight, for the credit consistency check.
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) pipe_cnt = pipe_cnt + OUT_W'(pipe_vld[i]);
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(pipe_vld[RD_LATENCY-1] && fifo_full && !pop));

  a_credit_sum : assert property (@(posedge clk) disable iff (rst)
    outstanding == pipe_cnt + fifo_count);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares every accepted response.
module tb_dmem_ctrl;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned RDEP  = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr_en;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wr_data;
  logic [3:0]    req_byte_en;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rd_data;
  logic          resp_err;

  dmem_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (LAT),
    .RESP_DEPTH (RDEP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_wr_en    (req_wr_en),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_wr_data),
    .i_req_byte_en  (req_byte_en),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_rd_data (resp_rd_data),
    .o_resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    bit            chk_lat;
    int            acc_cyc;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response the consumer takes must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got err=%0b data=0x%0h expected no response", resp_err, resp_rd_data);
      end else begin
        e = sb.pop_front();
        check({e.name, "_err"}, 64'(resp_err), 64'(e.err));
        check({e.name, "_data"}, 64'(resp_rd_data), 64'(e.data));
        if (e.chk_lat) check({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(LAT));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input string name, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [3:0] be,
                       input logic exp_err, input logic [DW-1:0] exp_data,
                       input bit chk_lat = 1'b0);
    int   n = 0;
    exp_t e;
    req_valid   = 1'b1;
    req_wr_en   = wr;
    req_addr    = addr;
    req_wr_data = wdata;
    req_byte_en = be;
    while (!req_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got ready=0 after %0d cycles expected ready=1", name, n);
      req_valid = 1'b0;
      return;
    end
    e.err     = exp_err;
    e.data    = exp_data;
    e.chk_lat = chk_lat;
    e.acc_cyc = cyc + 1;
    e.name    = name;
    sb.push_back(e);
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      step(1);
      n++;
    end
    check({name, "_drain_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_wr_en   = 1'b0;
    req_addr    = '0;
    req_wr_data = '0;
    req_byte_en = '0;
    resp_ready  = 1'b1;

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_data", 64'(resp_rd_data), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    step(2);
    rst = 1'b0;
    step(1);
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // Full-word store then load with latency check
    issue("st_100", 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    issue("ld_100", 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    drain("t1");

    // Byte-lane merging
    issue("st_40_ff", 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    issue("st_40_b0", 1'b1, 32'h40, 32'h000000AA, 4'b0001, 1'b0, 32'h0);
    issue("ld_40_a", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'hFFFFFFAA, 1'b1);
    issue("st_40_b13", 1'b1, 32'h40, 32'h12345678, 4'b1010, 1'b0, 32'h0);
    issue("ld_40_b", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h12FF56AA);
    drain("t2");

    // Backpressure: exactly RESP_DEPTH accepted, ready back after first pop
    for (int i = 0; i < 4; i++)
      issue($sformatf("pre_st_%0d", i), 1'b1, 32'h200 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, 1'b0, 32'h0);
    drain("t3_pre");
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue($sformatf("bp_ld_%0d", i), 1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0, 1'b0, 32'hA0000000 + 32'(i));
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    req_valid = 1'b1;
    req_wr_en = 1'b0;
    req_addr  = 32'h100;
    step(3);
    check("bp_ready_held", 64'(req_ready), 64'd0);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check("bp_ready_before_pop", 64'(req_ready), 64'd0);
    step(1);
    check("bp_ready_after_pop", 64'(req_ready), 64'd1);
    drain("t3");

    // Faults and boundaries
    issue("st_0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    issue("ld_misalign", 1'b0, 32'h102, 32'h0, 4'h0, 1'b1, 32'h0);
    issue("ld_oor", 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0);
    issue("st_oor", 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b1, 32'h0);
    issue("ld_0_noalias", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
    issue("st_last", 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0);
    issue("ld_last", 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, 32'h5A5A5A5A);
    drain("t4");

    // Full FIFO, then continuous accept/pop over 20 requests
    for (int i = 0; i < 24; i++)
      issue($sformatf("st_300_%0d", i), 1'b1, 32'h300 + 32'(4*i), 32'h10000000 + 32'(i), 4'hF, 1'b0, 32'h0);
    drain("t5_pre");
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue($sformatf("fill_ld_%0d", i), 1'b0, 32'h300 + 32'(4*i), 32'h0, 4'h0, 1'b0, 32'h10000000 + 32'(i));
    step(3);
    check("full_ready_low", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    c0 = cyc;
    for (int i = 4; i < 24; i++)
      issue($sformatf("stream_ld_%0d", i), 1'b0, 32'h300 + 32'(4*i), 32'h0, 4'h0, 1'b0, 32'h10000000 + 32'(i));
    check("stream_cycles", 64'(cyc - c0), 64'd21);
    drain("t5");

    // Reset with requests outstanding
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue($sformatf("rst_ld_%0d", i), 1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0, 1'b0, 32'hA0000000 + 32'(i));
    step(3);
    check("pre_rst_valid", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_data", 64'(resp_rd_data), 64'd0);
    check("mid_rst_err", 64'(resp_err), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    sb.delete();
    step(2);
    rst = 1'b0;
    resp_ready = 1'b1;
    step(8);
    check("post_rst_no_resp", 64'(resp_valid), 64'd0);
    check("post_rst_ready2", 64'(req_ready), 64'd1);
    issue("ld_100_after_rst", 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    issue("ld_40_after_rst", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h12FF56AA);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
